// File: rtl/pipelined_cla_adder.sv
// Pipelined carry-lookahead adder/subtractor with valid/ready flow control.
// Each stage adds one SEG-bit segment and hands the finished low bits, the
// remaining upper operand bits and its carry-out to the next stage.
module pipelined_cla_adder #(
   parameter int WIDTH  = 32,
   parameter int STAGES = 2
) (
   input  logic             iClk,
   input  logic             iRstN,
   input  logic             iValid,
   output logic             oReady,
   input  logic [WIDTH-1:0] iA,
   input  logic [WIDTH-1:0] iB,
   input  logic             iSub,
   input  logic             iC,
   output logic             oValid,
   input  logic             iReady,
   output logic [WIDTH-1:0] oS,
   output logic             oC,
   output logic             oV
);

   localparam int SEG = WIDTH / STAGES;
   localparam int NG  = SEG / 4;

   if ((STAGES < 1) || (STAGES > 8) || ((WIDTH % (4 * STAGES)) != 0)) begin : g_param_check
      $error("pipelined_cla_adder: STAGES must be 1..8 and WIDTH a multiple of 4*STAGES");
   end

   // One segment: 4-bit group lookahead, then a lookahead tier over up to
   // four groups; successive blocks of four groups chain their carries.
   function automatic logic [SEG:0] seg_add(input logic [SEG-1:0] a,
                                            input logic [SEG-1:0] b,
                                            input logic           cin);
      logic [SEG-1:0] g, p, c;
      logic [NG-1:0]  gg, gp;
      logic [NG:0]    gc;
      logic           t, u, ci;
      g  = a & b;
      p  = a | b;
      c  = '0;
      gc = '0;
      for (int i = 0; i < NG; i++) begin
         gg[i] = g[4*i+3] | (p[4*i+3] & g[4*i+2]) | (p[4*i+3] & p[4*i+2] & g[4*i+1])
               | (p[4*i+3] & p[4*i+2] & p[4*i+1] & g[4*i]);
         gp[i] = &p[4*i +: 4];
      end
      gc[0] = cin;
      for (int blk = 0; blk < NG; blk += 4) begin
         for (int j = 1; j <= 4; j++) begin
            if (blk + j <= NG) begin
               t = gc[blk];
               for (int m = blk; m < blk + j; m++) t = t & gp[m];
               for (int m = blk; m < blk + j; m++) begin
                  u = gg[m];
                  for (int n = m + 1; n < blk + j; n++) u = u & gp[n];
                  t = t | u;
               end
               gc[blk + j] = t;
            end
         end
      end
      for (int i = 0; i < NG; i++) begin
         ci         = gc[i];
         c[4*i]     = ci;
         c[4*i+1]   = g[4*i] | (p[4*i] & ci);
         c[4*i+2]   = g[4*i+1] | (p[4*i+1] & g[4*i]) | (p[4*i+1] & p[4*i] & ci);
         c[4*i+3]   = g[4*i+2] | (p[4*i+2] & g[4*i+1]) | (p[4*i+2] & p[4*i+1] & g[4*i])
                    | (p[4*i+2] & p[4*i+1] & p[4*i] & ci);
      end
      return {gc[NG], a ^ b ^ c};
   endfunction

   for (genvar k = 0; k < STAGES; k++) begin : g_stage
      localparam int IW = WIDTH - k * SEG;
      localparam int SW = (k + 1) * SEG;

      logic [IW-1:0]  a_in, b_in;
      logic           c_in, v_in, adv;
      logic [SEG:0]   seg_r;
      logic [SW-1:0]  s_next, s_q;
      logic           c_q, v_q;

      if (k == 0) begin : g_head
         assign a_in   = iA;
         assign b_in   = iB ^ {WIDTH{iSub}};
         assign c_in   = iC;
         assign v_in   = iValid;
         assign s_next = seg_r[SEG-1:0];
      end else begin : g_body
         assign a_in   = g_stage[k-1].g_fwd.a_q;
         assign b_in   = g_stage[k-1].g_fwd.b_q;
         assign c_in   = g_stage[k-1].c_q;
         assign v_in   = g_stage[k-1].v_q;
         assign s_next = {seg_r[SEG-1:0], g_stage[k-1].s_q};
      end

      assign seg_r = seg_add(a_in[SEG-1:0], b_in[SEG-1:0], c_in);

      always_ff @(posedge iClk) begin
         if (!iRstN) begin
            v_q <= 1'b0;
            s_q <= '0;
            c_q <= 1'b0;
         end else if (adv) begin
            v_q <= v_in;
            if (v_in) begin
               s_q <= s_next;
               c_q <= seg_r[SEG];
            end
         end
      end

      if (k == STAGES - 1) begin : g_last
         logic ov_q;
         assign adv = !v_q || iReady;
         // Only the operand MSBs matter here, so overflow is resolved now.
         always_ff @(posedge iClk) begin
            if (!iRstN) begin
               ov_q <= 1'b0;
            end else if (adv && v_in) begin
               ov_q <= (a_in[SEG-1] == b_in[SEG-1]) && (seg_r[SEG-1] != a_in[SEG-1]);
            end
         end
      end else begin : g_fwd
         logic [IW-SEG-1:0] a_q, b_q;
         assign adv = !v_q || g_stage[k+1].adv;
         always_ff @(posedge iClk) begin
            if (!iRstN) begin
               a_q <= '0;
               b_q <= '0;
            end else if (adv && v_in) begin
               a_q <= a_in[IW-1:SEG];
               b_q <= b_in[IW-1:SEG];
            end
         end
      end
   end

   assign oReady = iRstN && g_stage[0].adv;
   assign oValid = g_stage[STAGES-1].v_q;
   assign oS     = g_stage[STAGES-1].s_q;
   assign oC     = g_stage[STAGES-1].c_q;
   assign oV     = g_stage[STAGES-1].g_last.ov_q;

endmodule

// File: tb/tb_pipelined_cla_adder.sv
// Directed bench: a 32-bit/2-stage instance for arithmetic, latency and reset,
// and a 96-bit/3-stage instance for a backpressured stream.
module tb_pipelined_cla_adder;

   logic iClk = 1'b0;
   always #5 iClk = ~iClk;

   logic        rst_n;
   logic        a_ivalid, a_oready, a_isub, a_ic, a_ovalid, a_iready, a_oc, a_ov;
   logic [31:0] a_ia, a_ib, a_os;
   logic        b_ivalid, b_oready, b_isub, b_ic, b_ovalid, b_iready, b_oc, b_ov;
   logic [95:0] b_ia, b_ib, b_os;

   int   checks = 0;
   int   errors = 0;
   int   sent, got, occ, cyc;
   logic exp_rdy;
   logic drop_seen;
   logic [3:0] ready_pat;

   pipelined_cla_adder #(.WIDTH(32), .STAGES(2)) dut_a (
      .iClk(iClk), .iRstN(rst_n), .iValid(a_ivalid), .oReady(a_oready),
      .iA(a_ia), .iB(a_ib), .iSub(a_isub), .iC(a_ic),
      .oValid(a_ovalid), .iReady(a_iready), .oS(a_os), .oC(a_oc), .oV(a_ov)
   );

   pipelined_cla_adder #(.WIDTH(96), .STAGES(3)) dut_b (
      .iClk(iClk), .iRstN(rst_n), .iValid(b_ivalid), .oReady(b_oready),
      .iA(b_ia), .iB(b_ib), .iSub(b_isub), .iC(b_ic),
      .oValid(b_ovalid), .iReady(b_iready), .oS(b_os), .oC(b_oc), .oV(b_ov)
   );

   task automatic checkOutput(input string tag, input logic [127:0] observed,
                              input logic [127:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
      end
   endtask

   // One beat through the 32-bit instance with iReady high: accept, confirm the
   // result is not yet visible, then check it one edge later.
   task automatic applyStimulus(input string tag, input logic [31:0] a, input logic [31:0] b,
                                input logic sub, input logic cin, input logic [31:0] exp_s,
                                input logic exp_c, input logic exp_v);
      a_ia = a; a_ib = b; a_isub = sub; a_ic = cin; a_ivalid = 1'b1;
      #1 checkOutput({tag, "_ready"}, a_oready, 1);
      @(posedge iClk); #1;
      a_ivalid = 1'b0;
      checkOutput({tag, "_lat"}, a_ovalid, 0);
      @(posedge iClk); #1;
      checkOutput({tag, "_valid"}, a_ovalid, 1);
      checkOutput({tag, "_s"}, a_os, exp_s);
      checkOutput({tag, "_c"}, a_oc, exp_c);
      checkOutput({tag, "_v"}, a_ov, exp_v);
   endtask

   initial begin
      #100000;
      $display("[TB] FAIL watchdog expired before the bench completed");
      $fatal(1, "[TB] timeout");
   end

   initial begin
      $display("[TB] start");
      rst_n = 1'b0;
      a_ivalid = 1'b0; a_iready = 1'b1; a_ia = '0; a_ib = '0; a_isub = 1'b0; a_ic = 1'b0;
      b_ivalid = 1'b0; b_iready = 1'b1; b_ia = '0; b_ib = '0; b_isub = 1'b0; b_ic = 1'b0;
      repeat (2) @(posedge iClk);
      #1;
      checkOutput("rst_a_valid", a_ovalid, 0);
      checkOutput("rst_a_s", {a_oc, a_ov, a_os}, 0);
      checkOutput("rst_a_ready", a_oready, 0);
      checkOutput("rst_b_valid", b_ovalid, 0);
      checkOutput("rst_b_ready", b_oready, 0);
      rst_n = 1'b1;
      #1;
      checkOutput("rel_a_ready", a_oready, 1);
      checkOutput("rel_b_ready", b_oready, 1);
      @(posedge iClk); #1;

      applyStimulus("wrap",     32'hFFFF_FFFF, 32'h0000_0001, 0, 0, 32'h0000_0000, 1, 0);
      applyStimulus("ovf_add",  32'h7FFF_FFFF, 32'h0000_0001, 0, 0, 32'h8000_0000, 0, 1);
      applyStimulus("sub_neg",  32'h0000_0005, 32'h0000_0007, 1, 1, 32'hFFFF_FFFE, 0, 0);
      applyStimulus("ovf_sub",  32'h8000_0000, 32'h0000_0001, 1, 1, 32'h7FFF_FFFF, 1, 1);
      applyStimulus("sub_m1",   32'h0000_0010, 32'h0000_0003, 1, 0, 32'h0000_000C, 1, 0);
      applyStimulus("cin_seg",  32'h0000_FFFF, 32'h0000_0000, 0, 1, 32'h0001_0000, 0, 0);
      applyStimulus("mixed",    32'h1234_5678, 32'h9ABC_DEF0, 0, 0, 32'hACF1_3568, 0, 0);
      applyStimulus("neg_ovf",  32'h8000_0000, 32'h8000_0000, 0, 0, 32'h0000_0000, 1, 1);
      applyStimulus("sub_eq",   32'hDEAD_BEEF, 32'hDEAD_BEEF, 1, 1, 32'h0000_0000, 1, 0);
      applyStimulus("groups",   32'h0F0F_0F0F, 32'h0101_0101, 0, 0, 32'h1010_1010, 0, 0);

      // Reset with two beats in flight; the beat presented during reset is ignored.
      a_ia = 32'h1111_1111; a_ib = 32'h2222_2222; a_isub = 1'b0; a_ic = 1'b0; a_ivalid = 1'b1;
      @(posedge iClk); #1;
      a_ia = 32'h0101_0101; a_ib = 32'h1010_1010;
      @(posedge iClk); #1;
      checkOutput("mid_valid", a_ovalid, 1);
      checkOutput("mid_s", a_os, 32'h3333_3333);
      rst_n = 1'b0;
      a_ia = 32'hAAAA_AAAA; a_ib = 32'h5555_5555;
      #1 checkOutput("mid_rst_ready", a_oready, 0);
      @(posedge iClk); #1;
      checkOutput("flush_valid", a_ovalid, 0);
      checkOutput("flush_s", a_os, 0);
      checkOutput("flush_cv", {a_oc, a_ov}, 0);
      rst_n = 1'b1;
      a_ivalid = 1'b0;
      #1 checkOutput("flush_ready", a_oready, 1);
      @(posedge iClk); #1;
      checkOutput("post1_valid", a_ovalid, 0);
      @(posedge iClk); #1;
      checkOutput("post2_valid", a_ovalid, 0);
      applyStimulus("post_rst", 32'h0000_0003, 32'h0000_0004, 0, 0, 32'h0000_0007, 0, 0);

      // Stream of 10 beats into the 3-stage instance: all-ones plus (i+1)
      // wraps to i with carry-out, rippling through every segment.
      ready_pat = 4'b1001;
      sent = 0; got = 0; occ = 0; cyc = 0; drop_seen = 1'b0;
      b_ia = '1; b_isub = 1'b0; b_ic = 1'b0;
      while (got < 10 && cyc < 100) begin
         b_iready = ready_pat[cyc % 4];
         b_ivalid = (sent < 10);
         b_ib = 96'(sent + 1);
         #1;
         exp_rdy = !(occ == 3 && !b_iready);
         checkOutput($sformatf("bp_ready_c%0d", cyc), b_oready, exp_rdy);
         if (!b_oready) drop_seen = 1'b1;
         if (b_ovalid && b_iready) begin
            checkOutput($sformatf("bp_s_%0d", got), b_os, 96'(got));
            checkOutput($sformatf("bp_cv_%0d", got), {b_oc, b_ov}, 2'b10);
            got++;
            occ--;
         end
         if (b_ivalid && b_oready) begin
            sent++;
            occ++;
         end
         @(posedge iClk); #1;
         cyc++;
      end
      checkOutput("bp_count", got, 10);
      checkOutput("bp_drop_seen", drop_seen, 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
